id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised decode stage that is the successor to the single-cycle decode unit. It decodes the IF/ID instruction and reads an NREGS-entry register file with write-through. A load-use hazard FSM inserts a configurable number of bubbles (LOAD_LAT). The stage owns the registered ID/EX pipeline boundary, with valid, stall and flush handling. It sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 32, datapath and register width.
NREGS, 32, architectural register count; RS_W = clog2(NREGS); x0 is hardwired to zero.
LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..3).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous active-low reset.
if_valid  in  1  IF/ID holds a valid instruction.
if_instr  in  XLEN  instruction word.
if_pc  in  XLEN  PC of the instruction.
flush  in  1  branch/jump redirect from EX; kills the ID contents.
ex_rd  in  RS_W  rd currently in EX.
ex_memread  in  1  EX instruction is a load.
ex_valid  in  1  EX slot is valid.
wb_we  in  1  writeback enable.
wb_rd  in  RS_W  writeback destination.
wb_data  in  XLEN  writeback data.
stall  out  1  hold PC and IF/ID (pcwrite/ifidwrite = !stall).
idex_valid  out  1  ID/EX slot is valid.
idex_pc, idex_rdata1, idex_rdata2, idex_imm  out  XLEN  registered operands.
idex_rs1, idex_rs2, idex_rd  out  RS_W  registered register indices.
idex_funct3  out  3  registered funct3.
idex_inst30  out  1  registered instruction bit 30.
idex_ctrl  out  12  {branch, memread, memtoreg, aluop[1:0], memwrite, alusrc, regwrite, aluinputpc, branchjalx, alu2pc, illegal}.

Behaviour:
- Reset (rst=0, asynchronous): all idex_* outputs = 0, stall = 0, FSM = RUN, stall counter = 0, all register file entries = 0.
- Decode (combinational):
  - rs1 is forced to 0 for LUI.
  - use_rs1 = 0 for LUI, AUIPC, JAL.
  - use_rs2 = 1 only for R, S, B opcodes.
  - Immediate generation covers I/S/B/U/J formats, sign-extended to XLEN.
  - An unknown opcode sets the illegal bit, clears all write/memory controls, and keeps valid.
- Register file:
  - Write on the rising edge when wb_we=1 and wb_rd != 0; writes to x0 are ignored.
  - Reads are asynchronous; index 0 always returns 0.
- Hazard detection: hz = if_valid & ex_valid & ex_memread & (ex_rd != 0) & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
- FSM:
  - RUN: when hz=1 and flush=0, go to STALL with cnt = LOAD_LAT-1; stall=1 in that same cycle.
  - STALL: stall=1; cnt decrements each cycle; when cnt==0 and the stall cycle ends, go to RUN.
  - Total bubbles inserted = LOAD_LAT.
  - While in STALL, hz is not re-evaluated.
- ID/EX update every cycle, in priority order:
  1. flush=1: idex_valid <= 0, idex_ctrl <= 0, FSM forced to RUN, cnt <= 0. Flush wins over a simultaneous hz.
  2. stall=1: bubble, i.e. idex_valid <= 0 and idex_ctrl <= 0. Data fields may hold any value.
  3. Otherwise: capture the decoded instruction; idex_valid <= if_valid. When if_valid=0, idex_ctrl <= 0.
- Latency: one cycle from if_instr to idex_*.
- Reset asserted mid-stall returns to RUN with no bubble pending.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: same-cycle write-through. When wb_we=1, wb_rd != 0 and wb_rd equals a read index, that read returns wb_data.
- Undefined: reads return the pre-write value. The hazard term additionally includes (wb_we & wb_rd != 0 & a used source matches wb_rd), which forces a single-cycle stall through the same FSM with cnt = 0.

Decomposition:
- Shared package (riscv_def): OP_* opcode constants, field slice ranges, the IDEX_CTRL bit-index constants, the ctrl struct/typedef, and the aluop encoding (00 add, 01 branch, 10 R, 11 I).
- One sub-module, id_regfile (parameters XLEN and NREGS, plus the bypass macro).
- Decode, immediate generation, hazard detection and the FSM stay in id_stage_pipe.

Test Plan:
- Reset then `ADD x3,x1,x2` with if_valid=1 → next cycle idex_valid=1, aluop=10, regwrite=1, rs1=1, rs2=2, rd=3.
- EX holds a valid `LW x5`; ID holds `ADD x6,x5,x7`; LOAD_LAT=2 → stall=1 for exactly 2 cycles, 2 bubbles (idex_valid=0), then the ADD is issued.
- Same as above but the ADD is `LUI x6,0x12345` → no stall; idex_imm=0x12345000, idex_rs1=0.
- Load-use hazard and flush=1 in the same cycle → stall=0, idex_valid=0, FSM in RUN; the next instruction issues normally.
- wb_we=1, wb_rd=4, wb_data=0xDEADBEEF; ID reads x4:
  - macro defined → idex_rdata1=0xDEADBEEF with no stall.
  - macro undefined → 1 stall cycle, then 0xDEADBEEF.
- wb_we=1 with wb_rd=0 and data 0xFFFFFFFF, then a read of x0 → 0; opcode 0x7F → illegal=1, memwrite=0, regwrite=0.

Source files
------------

// File: rtl/riscv_def_pkg.sv
// riscv_def: shared RV32 decode definitions for the ID stage.
//   - OP_* opcode constants and instruction field positions
//   - IDEX control-word bit indices, the control struct and the aluop encoding
//   - decode_ctrl(): opcode -> control word
//   - gen_imm():     I/S/B/U/J immediate, sign-extended to 32 bits
package riscv_def;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Field positions (LSB of each field)
    localparam int RD_LSB     = 7;
    localparam int F3_LSB     = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int INST30_BIT = 30;

    // aluop encoding
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    // IDEX control-word bit indices
    localparam int IDEX_CTRL_W      = 12;
    localparam int CTRL_ILLEGAL     = 0;
    localparam int CTRL_ALU2PC      = 1;
    localparam int CTRL_BRANCHJALX  = 2;
    localparam int CTRL_ALUINPUTPC  = 3;
    localparam int CTRL_REGWRITE    = 4;
    localparam int CTRL_ALUSRC      = 5;
    localparam int CTRL_MEMWRITE    = 6;
    localparam int CTRL_ALUOP_LO    = 7;
    localparam int CTRL_ALUOP_HI    = 8;
    localparam int CTRL_MEMTOREG    = 9;
    localparam int CTRL_MEMREAD     = 10;
    localparam int CTRL_BRANCH      = 11;

    // First member is the MSB, so the packed layout matches the indices above.
    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       aluinputpc;
        logic       branchjalx;
        logic       alu2pc;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {ST_RUN, ST_STALL} hz_state_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_REG:    begin c.aluop = ALUOP_R; c.regwrite = 1'b1; end
            OP_IMM:    begin c.aluop = ALUOP_I; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_LOAD:   begin
                c.memread = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
            end
            OP_STORE:  begin c.memwrite = 1'b1; c.alusrc = 1'b1; end
            OP_BRANCH: begin c.branch = 1'b1; c.aluop = ALUOP_BRANCH; end
            // rs1 is forced to x0, so the ALU computes 0 + imm.
            OP_LUI:    begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_AUIPC:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluinputpc = 1'b1; end
            // JAL target = pc + imm; JALR target = rs1 + imm taken from the ALU.
            OP_JAL:    begin
                c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluinputpc = 1'b1; c.branchjalx = 1'b1;
            end
            OP_JALR:   begin
                c.alusrc = 1'b1; c.regwrite = 1'b1; c.branchjalx = 1'b1; c.alu2pc = 1'b1;
            end
            default:   c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREGS x XLEN register file, x0 hardwired to zero.
//   clk, rst        clock, asynchronous active-low reset (clears every entry)
//   we/waddr/wdata  rising-edge write port; writes to x0 are dropped
//   raddr1/rdata1   asynchronous read port 1
//   raddr2/rdata2   asynchronous read port 2
// Build option ID_WB_BYPASS_EN: a same-cycle write to a read index is
// forwarded to that read port; otherwise reads return the pre-write value.
module id_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RS_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RS_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RS_W-1:0] raddr1,
    input  logic [RS_W-1:0] raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // NOTE: the array is reset because the architecture promises zeroed
    // registers after reset; this costs a reset net on every flop, so it
    // cannot map onto a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef ID_WB_BYPASS_EN
        if (we && waddr != '0 && waddr == raddr1) rdata1 = wdata;
        if (we && waddr != '0 && waddr == raddr2) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32 decode stage with register file, load-use hazard FSM
// and the registered ID/EX boundary.
//   clk, rst                     clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc      IF/ID contents
//   flush                        redirect from EX, kills the ID contents
//   ex_rd/ex_memread/ex_valid    instruction currently in EX
//   wb_we/wb_rd/wb_data          writeback port
//   stall                        hold PC and IF/ID
//   idex_*                       registered ID/EX outputs
// Build option ID_WB_BYPASS_EN: register-file write-through. Without it a
// source matching the in-flight writeback costs one stall cycle instead.
module id_stage_pipe
    import riscv_def::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int LOAD_LAT = 1,
    localparam int RS_W     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic [RS_W-1:0] ex_rd,
    input  logic            ex_memread,
    input  logic            ex_valid,
    input  logic            wb_we,
    input  logic [RS_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_rdata1,
    output logic [XLEN-1:0] idex_rdata2,
    output logic [XLEN-1:0] idex_imm,
    output logic [RS_W-1:0] idex_rs1,
    output logic [RS_W-1:0] idex_rs2,
    output logic [RS_W-1:0] idex_rd,
    output logic [2:0]      idex_funct3,
    output logic            idex_inst30,
    output logic [11:0]     idex_ctrl
);

    // The detecting RUN cycle is the first bubble; STALL covers the other
    // LOAD_LAT-1. cnt holds the STALL cycles still owed after the current one.
    localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    // ---------------- decode ----------------
    logic [6:0]      opcode;
    logic            is_lui, use_rs1, use_rs2;
    logic [RS_W-1:0] rs1, rs2, rd;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rdata1, rdata2;

    assign opcode   = if_instr[6:0];
    assign is_lui   = (opcode == OP_LUI);
    assign use_rs1  = !(is_lui || opcode == OP_AUIPC || opcode == OP_JAL);
    assign use_rs2  = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign rs1      = is_lui ? '0 : if_instr[RS1_LSB +: RS_W];
    assign rs2      = if_instr[RS2_LSB +: RS_W];
    assign rd       = if_instr[RD_LSB +: RS_W];
    assign dec_ctrl = decode_ctrl(opcode);
    assign imm      = XLEN'($signed(gen_imm(if_instr[31:0])));

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // ---------------- hazard detection ----------------
    logic load_hz, wb_hz, hz;

    assign load_hz = if_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                     ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
`ifdef ID_WB_BYPASS_EN
    assign wb_hz = 1'b0;
`else
    assign wb_hz = if_valid && wb_we && (wb_rd != '0) &&
                   ((use_rs1 && rs1 == wb_rd) || (use_rs2 && rs2 == wb_rd));
`endif
    assign hz = load_hz || wb_hz;

    // ---------------- stall FSM ----------------
    hz_state_t  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz) begin
                        stall = 1'b1;
                        // A writeback hazard needs just this one cycle.
                        if (load_hz && LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    stall = 1'b1;
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - 2'd1;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- ID/EX boundary ----------------
    // Data fields load every cycle; only valid and ctrl decide whether EX
    // sees an instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_valid  <= 1'b0;
            idex_ctrl   <= '0;
            idex_pc     <= '0;
            idex_rdata1 <= '0;
            idex_rdata2 <= '0;
            idex_imm    <= '0;
            idex_rs1    <= '0;
            idex_rs2    <= '0;
            idex_rd     <= '0;
            idex_funct3 <= '0;
            idex_inst30 <= 1'b0;
        end else begin
            idex_pc     <= if_pc;
            idex_rdata1 <= rdata1;
            idex_rdata2 <= rdata2;
            idex_imm    <= imm;
            idex_rs1    <= rs1;
            idex_rs2    <= rs2;
            idex_rd     <= rd;
            idex_funct3 <= if_instr[F3_LSB +: 3];
            idex_inst30 <= if_instr[INST30_BIT];
            if (flush || stall) begin
                idex_valid <= 1'b0;
                idex_ctrl  <= '0;
            end else begin
                idex_valid <= if_valid;
                idex_ctrl  <= if_valid ? dec_ctrl : '0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe
// (LOAD_LAT = 2). Decode vectors come from a table; hazard, flush,
// writeback and reset corner cases are hand-written sequences.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid, flush, ex_memread, ex_valid, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  ex_rd, wb_rd;
    logic        stall, idex_valid, idex_inst30;
    logic [31:0] idex_pc, idex_rdata1, idex_rdata2, idex_imm;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [2:0]  idex_funct3;
    logic [11:0] idex_ctrl;

    id_stage_pipe #(.XLEN(32), .NREGS(32), .LOAD_LAT(2)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_valid(ex_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rdata1(idex_rdata1),
        .idex_rdata2(idex_rdata2), .idex_imm(idex_imm), .idex_rs1(idex_rs1),
        .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_funct3(idex_funct3),
        .idex_inst30(idex_inst30), .idex_ctrl(idex_ctrl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic drive_id(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1; if_instr = instr; if_pc = pc;
    endtask

    // Control words: {branch,memread,memtoreg,aluop[1:0],memwrite,alusrc,
    //                 regwrite,aluinputpc,branchjalx,alu2pc,illegal}
    localparam logic [11:0] C_R = 12'h110, C_I = 12'h1B0, C_LD = 12'h630, C_ST = 12'h060;
    localparam logic [11:0] C_BR = 12'h880, C_JAL = 12'h03C, C_JALR = 12'h036;
    localparam logic [11:0] C_LUI = 12'h030, C_AUIPC = 12'h038, C_ILL = 12'h001;

    localparam logic [31:0] ADD_3_1_2  = 32'h002081B3;
    localparam logic [31:0] ADD_6_5_7  = 32'h00728333;
    localparam logic [31:0] LUI_6      = 32'h12345337;
    localparam logic [31:0] ADDI_8_4_M1 = 32'hFFF20413;
    localparam logic [31:0] ADDI_9_0_5 = 32'h00500493;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2;
        logic [2:0]  f3;
        logic        i30;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            instr          v  ctrl     imm           rs1 rs2 rd  rdata1 rdata2 f3 i30
        vecs[0]  = '{ADD_3_1_2,     1, C_R,     32'h0,        1,  2,  3,  32'h11, 32'h22, 0, 0};
        vecs[1]  = '{32'h402081B3,  1, C_R,     32'h0,        1,  2,  3,  32'h11, 32'h22, 0, 1};
        vecs[2]  = '{ADDI_8_4_M1,   1, C_I,     32'hFFFFFFFF, 4,  31, 8,  32'h0,  32'h0,  0, 1};
        vecs[3]  = '{32'hFFC12503,  1, C_LD,    32'hFFFFFFFC, 2,  28, 10, 32'h22, 32'h0,  2, 1};
        vecs[4]  = '{32'h0020A423,  1, C_ST,    32'h8,        1,  2,  8,  32'h11, 32'h22, 2, 0};
        vecs[5]  = '{32'hFE208EE3,  1, C_BR,    32'hFFFFFFFC, 1,  2,  29, 32'h11, 32'h22, 0, 1};
        vecs[6]  = '{32'h008000EF,  1, C_JAL,   32'h8,        0,  8,  1,  32'h0,  32'h0,  0, 0};
        vecs[7]  = '{LUI_6,         1, C_LUI,   32'h12345000, 0,  3,  6,  32'h0,  32'h0,  5, 0};
        vecs[8]  = '{32'h00001297,  1, C_AUIPC, 32'h1000,     0,  0,  5,  32'h0,  32'h0,  1, 0};
        vecs[9]  = '{32'h000100E7,  1, C_JALR,  32'h0,        2,  0,  1,  32'h22, 32'h0,  0, 0};
        vecs[10] = '{32'h0000007F,  1, C_ILL,   32'h0,        0,  0,  0,  32'h0,  32'h0,  0, 0};
        vecs[11] = '{ADD_3_1_2,     0, 12'h0,   32'h0,        1,  2,  3,  32'h11, 32'h22, 0, 0};

        // ---- reset ----
        idle();
        #2 rst = 1'b0;
        #2;
        check("rst.stall", 32'(stall), 0);
        check("rst.valid", 32'(idex_valid), 0);
        check("rst.ctrl", 32'(idex_ctrl), 0);
        check("rst.pc", idex_pc, 0);
        check("rst.imm", idex_imm, 0);
        check("rst.rd", 32'(idex_rd), 0);
        drive_id(ADD_3_1_2, 32'h40);
        tick();
        check("rst.held_valid", 32'(idex_valid), 0);
        idle();
        @(negedge clk) rst = 1'b1;

        // ---- preload x1, x2, x5, x7 (if_valid=0, no hazards) ----
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        wb_write(5'd5, 32'h55);
        wb_write(5'd7, 32'h77);

        // ---- decode table ----
        for (int i = 0; i < NV; i++) begin
            if_valid = vecs[i].valid;
            if_instr = vecs[i].instr;
            if_pc    = 32'h1000 + 32'(i * 4);
            #1;
            check($sformatf("v%0d.stall", i), 32'(stall), 0);
            tick();
            check($sformatf("v%0d.valid", i), 32'(idex_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d.ctrl", i), 32'(idex_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("v%0d.imm", i), idex_imm, vecs[i].imm);
            check($sformatf("v%0d.rs1", i), 32'(idex_rs1), 32'(vecs[i].rs1));
            check($sformatf("v%0d.rs2", i), 32'(idex_rs2), 32'(vecs[i].rs2));
            check($sformatf("v%0d.rd", i), 32'(idex_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d.rdata1", i), idex_rdata1, vecs[i].rd1);
            check($sformatf("v%0d.rdata2", i), idex_rdata2, vecs[i].rd2);
            check($sformatf("v%0d.funct3", i), 32'(idex_funct3), 32'(vecs[i].f3));
            check($sformatf("v%0d.inst30", i), 32'(idex_inst30), 32'(vecs[i].i30));
            check($sformatf("v%0d.pc", i), idex_pc, 32'h1000 + 32'(i * 4));
        end
        idle();
        tick();

        // ---- load-use: EX LW x5, ID ADD x6,x5,x7 -> 2 bubbles ----
        drive_id(ADD_6_5_7, 32'h200);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        #1 check("lu.stall0", 32'(stall), 1);
        tick();
        check("lu.bubble1", 32'(idex_valid), 0);
        check("lu.bubble1_ctrl", 32'(idex_ctrl), 0);
        check("lu.stall1", 32'(stall), 1);
        tick();
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        #1;
        check("lu.bubble2", 32'(idex_valid), 0);
        check("lu.stall2", 32'(stall), 0);
        tick();
        check("lu.issue_valid", 32'(idex_valid), 1);
        check("lu.issue_rd", 32'(idex_rd), 6);
        check("lu.issue_rdata1", idex_rdata1, 32'h55);
        check("lu.issue_rdata2", idex_rdata2, 32'h77);
        check("lu.issue_ctrl", 32'(idex_ctrl), 32'(C_R));

        // ---- LUI behind the load: no hazard even though rs1 field = ex_rd ----
        drive_id(LUI_6, 32'h300);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;
        #1 check("lui.stall", 32'(stall), 0);
        tick();
        check("lui.valid", 32'(idex_valid), 1);
        check("lui.imm", idex_imm, 32'h12345000);
        check("lui.rs1", 32'(idex_rs1), 0);

        // ---- hazard and flush together ----
        drive_id(ADD_6_5_7, 32'h400);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; flush = 1'b1;
        #1 check("fl.stall", 32'(stall), 0);
        tick();
        check("fl.valid", 32'(idex_valid), 0);
        check("fl.ctrl", 32'(idex_ctrl), 0);
        idle();
        drive_id(ADD_3_1_2, 32'h404);
        #1 check("fl.next_stall", 32'(stall), 0);
        tick();
        check("fl.next_valid", 32'(idex_valid), 1);
        check("fl.next_rd", 32'(idex_rd), 3);

        // ---- writeback to a source being read ----
        idle();
        drive_id(ADDI_8_4_M1, 32'h500);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEADBEEF;
`ifdef ID_WB_BYPASS_EN
        #1 check("wb.stall", 32'(stall), 0);
        tick();
        wb_we = 1'b0;
        check("wb.valid", 32'(idex_valid), 1);
        check("wb.rdata1", idex_rdata1, 32'hDEADBEEF);
`else
        #1 check("wb.stall", 32'(stall), 1);
        tick();
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        check("wb.bubble", 32'(idex_valid), 0);
        #1 check("wb.stall_end", 32'(stall), 0);
        tick();
        check("wb.valid", 32'(idex_valid), 1);
        check("wb.rdata1", idex_rdata1, 32'hDEADBEEF);
`endif

        // ---- write to x0 is ignored, same cycle and later ----
        idle();
        drive_id(ADDI_9_0_5, 32'h600);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        #1 check("x0.stall", 32'(stall), 0);
        tick();
        check("x0.rdata1_same", idex_rdata1, 0);
        wb_we = 1'b0;
        tick();
        check("x0.rdata1_after", idex_rdata1, 0);
        check("x0.imm", idex_imm, 5);

        // ---- reset in the middle of a stall ----
        idle();
        drive_id(ADD_6_5_7, 32'h700);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        tick();
        check("mr.stall_state", 32'(stall), 1);
        #2 rst = 1'b0;
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        #1;
        check("mr.stall", 32'(stall), 0);
        check("mr.valid", 32'(idex_valid), 0);
        @(negedge clk) rst = 1'b1;
        #1 check("mr.no_pending", 32'(stall), 0);
        tick();
        check("mr.issue_valid", 32'(idex_valid), 1);
        check("mr.regfile_cleared", idex_rdata1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
